// File: rtl/disp_pixel_fifo.sv
// Display pixel FIFO: buffers packed DMA words and unpacks them to one registered
// pixel per DSP_preDE, with fill level, threshold ready, sticky error flags and flush.
module disp_pixel_fifo #(
  parameter int PIX_W     = 24,
  parameter int PPW       = 2,
  parameter int DEPTH     = 512,
  parameter int WR_THRESH = 128,
  parameter logic [PIX_W-1:0] BLANK = '0
) (
  input  logic                     ACLK,
  input  logic                     ARSTN,
  input  logic                     CLR,
  input  logic                     DISPON,
  input  logic [32*PPW-1:0]        FIFOIN,
  input  logic                     FIFOWR,
  input  logic                     DSP_preDE,
  output logic                     BUF_WREADY,
  output logic                     BUF_OVER,
  output logic                     BUF_UNDER,
  output logic [$clog2(DEPTH):0]   BUF_LEVEL,
  output logic [PIX_W/3-1:0]       DSP_R,
  output logic [PIX_W/3-1:0]       DSP_G,
  output logic [PIX_W/3-1:0]       DSP_B,
  output logic                     DSP_DE
);
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int CW   = PIX_W / 3;
  localparam int PH_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PPW - 1);
  localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH);

  logic [32*PPW-1:0] mem [DEPTH];

  logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [32*PPW-1:0] hold_q, hold_d;
  logic              hold_v_q, hold_v_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              over_q, over_d;
  logic              under_q, under_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic              de_q;

  logic              full, empty, wr_en, pop;
  logic [PIX_W-1:0]  lane [PPW];

  generate
    for (genvar gi = 0; gi < PPW; gi++) begin : g_lane
      assign lane[gi] = hold_q[32*gi +: PIX_W];
    end
  endgenerate

  always_comb begin
    full  = (level_q == DEPTH_L);
    empty = (level_q == '0);
    wr_en = FIFOWR & ~full;
    // The hold register refills whenever it is empty, or as its last lane is shown.
    pop   = ~empty & (~hold_v_q | (DSP_preDE & (phase_q == PH_LAST)));

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LW'(wr_en) - LW'(pop);
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    phase_d  = phase_q;
    over_d   = over_q | (FIFOWR & full);
    under_d  = under_q;
    pix_d    = pix_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;

    if (DSP_preDE) begin
      if (hold_v_q) begin
        pix_d = DISPON ? lane[phase_q] : BLANK;
        if (phase_q != PH_LAST) begin
          phase_d = phase_q + 1'b1;
        end else begin
          phase_d  = '0;
          hold_v_d = pop;
        end
      end else begin
        pix_d = BLANK;
        if (DISPON) under_d = 1'b1;
      end
    end

    if (pop) begin
      hold_d   = mem[rd_ptr_q[AW-1:0]];
      hold_v_d = 1'b1;
      phase_d  = '0;
    end

    // Flush discards any same-cycle write or pop; pixel output path is left alone.
    if (CLR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      hold_v_d = 1'b0;
      phase_d  = '0;
      over_d   = 1'b0;
      under_d  = 1'b0;
    end
  end

  // Head word is read combinationally so it can land in the hold register on pop.
  always_ff @(posedge ACLK) begin
    if (wr_en & ~CLR) mem[wr_ptr_q[AW-1:0]] <= FIFOIN;
  end

  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      phase_q  <= '0;
      over_q   <= 1'b0;
      under_q  <= 1'b0;
      pix_q    <= '0;
      de_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      phase_q  <= phase_d;
      over_q   <= over_d;
      under_q  <= under_d;
      pix_q    <= pix_d;
      de_q     <= DSP_preDE;
    end
  end

  assign BUF_WREADY = (int'(DEPTH) - int'(level_q)) >= WR_THRESH;
  assign BUF_OVER   = over_q;
  assign BUF_UNDER  = under_q;
  assign BUF_LEVEL  = level_q;
  assign DSP_R      = pix_q[PIX_W-1 -: CW];
  assign DSP_G      = pix_q[2*CW-1 -: CW];
  assign DSP_B      = pix_q[CW-1:0];
  assign DSP_DE     = de_q;

endmodule

// File: tb/tb_disp_pixel_fifo.sv
// Scoreboard bench: stimulus queues expected pixels, negedge monitors pop and compare.
module tb_disp_pixel_fifo;
  logic        clk = 1'b0;
  logic        rst_n, clr, dispon, fifowr, pre_de;
  logic [63:0] fifoin;
  logic        wready, over, under, de;
  logic [9:0]  level;
  logic [7:0]  r, g, b;

  logic         rst4_n, wr4, pde4;
  logic [127:0] din4;
  logic         wready4, over4, under4, de4;
  logic [4:0]   level4;
  logic [7:0]   r4, g4, b4;

  int n_cmp = 0;
  int n_bad = 0;
  int pix_n = 0;
  int pix4_n = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp4_q[$];
  logic pre_de_d, pde4_d;

  always #5 clk = ~clk;

  disp_pixel_fifo dut (
    .ACLK(clk), .ARSTN(rst_n), .CLR(clr), .DISPON(dispon), .FIFOIN(fifoin),
    .FIFOWR(fifowr), .DSP_preDE(pre_de), .BUF_WREADY(wready), .BUF_OVER(over),
    .BUF_UNDER(under), .BUF_LEVEL(level), .DSP_R(r), .DSP_G(g), .DSP_B(b), .DSP_DE(de)
  );

  disp_pixel_fifo #(.PIX_W(24), .PPW(4), .DEPTH(16), .WR_THRESH(4)) dut4 (
    .ACLK(clk), .ARSTN(rst4_n), .CLR(1'b0), .DISPON(1'b1), .FIFOIN(din4),
    .FIFOWR(wr4), .DSP_preDE(pde4), .BUF_WREADY(wready4), .BUF_OVER(over4),
    .BUF_UNDER(under4), .BUF_LEVEL(level4), .DSP_R(r4), .DSP_G(g4), .DSP_B(b4), .DSP_DE(de4)
  );

  // Reference for DE: preDE delayed one clock, cleared by reset.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pre_de_d <= 1'b0; else pre_de_d <= pre_de;
  always @(posedge clk or negedge rst4_n)
    if (!rst4_n) pde4_d <= 1'b0; else pde4_d <= pde4;

  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (de !== pre_de_d) begin
        n_bad++;
        $display("FAIL de: got %0b required %0b", de, pre_de_d);
      end
      if (de === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL pix_unexpected: got %h required none", {r, g, b});
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          if ({r, g, b} !== e) begin
            n_bad++;
            $display("FAIL pix %0d: got %h required %h", pix_n, {r, g, b}, e);
          end else $display("pix %0d: %h", pix_n, e);
          pix_n++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst4_n) begin
      n_cmp++;
      if (de4 !== pde4_d) begin
        n_bad++;
        $display("FAIL de4: got %0b required %0b", de4, pde4_d);
      end
      if (de4 === 1'b1) begin
        n_cmp++;
        if (exp4_q.size() == 0) begin
          n_bad++;
          $display("FAIL pix4_unexpected: got %h required none", {r4, g4, b4});
        end else begin
          logic [23:0] e;
          e = exp4_q.pop_front();
          if ({r4, g4, b4} !== e) begin
            n_bad++;
            $display("FAIL pix4 %0d: got %h required %h", pix4_n, {r4, g4, b4}, e);
          end else $display("pix4 %0d: %h", pix4_n, e);
          pix4_n++;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end else $display("chk %s: %0h", name, got);
  endtask

  task automatic step(input logic wr, input logic [63:0] d, input logic pde, input logic [23:0] e);
    fifowr = wr;
    fifoin = d;
    pre_de = pde;
    if (pde) exp_q.push_back(e);
    @(negedge clk);
    fifowr = 1'b0;
    pre_de = 1'b0;
  endtask

  task automatic step4(input logic wr, input logic [127:0] d, input logic pde, input logic [23:0] e);
    wr4  = wr;
    din4 = d;
    pde4 = pde;
    if (pde) exp4_q.push_back(e);
    @(negedge clk);
    wr4  = 1'b0;
    pde4 = 1'b0;
  endtask

  // Word i carries pixels 2i (lane 0) and 2i+1 (lane 1); upper lane bytes are junk.
  function automatic logic [63:0] mkw(input int i);
    mkw = {8'hA5, 24'(2*i + 1), 8'hA5, 24'(2*i)};
  endfunction

  function automatic logic [23:0] px4(input int k, input int l);
    px4 = 24'(32'h0A0000 + 16*k + l);
  endfunction

  function automatic logic [127:0] w4(input int k);
    logic [127:0] w;
    for (int l = 0; l < 4; l++) w[32*l +: 32] = {8'h5A, px4(k, l)};
    w4 = w;
  endfunction

  initial begin
    logic [63:0] w1;
    rst_n = 1'b0; rst4_n = 1'b0; clr = 1'b0; dispon = 1'b1;
    fifowr = 1'b0; pre_de = 1'b0; fifoin = '0;
    wr4 = 1'b0; pde4 = 1'b0; din4 = '0;
    repeat (3) @(negedge clk);
    chk("rst_level", 32'(level), 0);
    chk("rst_wready", 32'(wready), 1);
    chk("rst_over", 32'(over), 0);
    chk("rst_under", 32'(under), 0);
    chk("rst_rgb", 32'({r, g, b}), 0);
    chk("rst_de", 32'(de), 0);
    rst_n = 1'b1; rst4_n = 1'b1;
    @(negedge clk);

    // Basic unpack order: lane 0 first.
    w1 = {32'h00112233, 32'h00445566};
    for (int i = 0; i < 4; i++) step(1'b1, w1, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    for (int j = 0; j < 8; j++) step(1'b0, '0, 1'b1, (j % 2 == 1) ? 24'h112233 : 24'h445566);
    chk("t1_under", 32'(under), 0);
    chk("t1_level", 32'(level), 0);

    // Fill to 512 words plus one in the hold register, with threshold sweep.
    for (int i = 0; i < 513; i++) begin
      step(1'b1, mkw(i), 1'b0, '0);
      if (i == 384) chk("wready_384", 32'(wready), 1);
      if (i == 385) chk("wready_385", 32'(wready), 0);
    end
    chk("full_level", 32'(level), 512);
    chk("full_over", 32'(over), 0);
    step(1'b1, mkw(513), 1'b0, '0);
    chk("over_set", 32'(over), 1);
    chk("over_level", 32'(level), 512);
    for (int j = 0; j < 1026; j++) step(1'b0, '0, 1'b1, 24'(j));
    chk("drain_level", 32'(level), 0);
    chk("drain_wready", 32'(wready), 1);
    chk("over_sticky", 32'(over), 1);
    clr = 1'b1; step(1'b0, '0, 1'b0, '0); clr = 1'b0;
    chk("clr_over", 32'(over), 0);

    // Simultaneous write and pop keeps the level.
    for (int i = 600; i < 603; i++) step(1'b1, mkw(i), 1'b0, '0);
    step(1'b0, '0, 1'b1, 24'(1200));
    step(1'b1, mkw(603), 1'b1, 24'(1201));
    chk("wr_pop_level", 32'(level), 2);
    for (int j = 1202; j < 1208; j++) step(1'b0, '0, 1'b1, 24'(j));
    chk("wr_pop_drain", 32'(level), 0);

    // Underflow with display on, then off.
    for (int j = 0; j < 3; j++) step(1'b0, '0, 1'b1, 24'h0);
    chk("under_on", 32'(under), 1);
    repeat (2) step(1'b0, '0, 1'b0, '0);
    chk("under_sticky", 32'(under), 1);
    clr = 1'b1; step(1'b0, '0, 1'b0, '0); clr = 1'b0;
    chk("under_clr", 32'(under), 0);
    dispon = 1'b0;
    for (int j = 0; j < 3; j++) step(1'b0, '0, 1'b1, 24'h0);
    chk("under_off", 32'(under), 0);
    step(1'b1, mkw(700), 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 24'h0);
    step(1'b0, '0, 1'b1, 24'h0);
    chk("dispoff_level", 32'(level), 0);
    chk("dispoff_under", 32'(under), 0);
    dispon = 1'b1;
    step(1'b0, '0, 1'b1, 24'h0);
    chk("dispoff_consumed", 32'(under), 1);
    clr = 1'b1; step(1'b0, '0, 1'b0, '0); clr = 1'b0;

    // Flush during streaming; same-cycle write is discarded.
    for (int i = 800; i < 803; i++) step(1'b1, mkw(i), 1'b0, '0);
    step(1'b0, '0, 1'b1, 24'(1600));
    chk("pre_clr_level", 32'(level), 2);
    clr = 1'b1; step(1'b1, mkw(803), 1'b0, '0); clr = 1'b0;
    chk("clr_level", 32'(level), 0);
    chk("clr_under", 32'(under), 0);
    step(1'b0, '0, 1'b1, 24'h0);
    chk("post_clr_under", 32'(under), 1);
    step(1'b1, mkw(810), 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 24'(1620));
    step(1'b0, '0, 1'b1, 24'(1621));
    chk("resume_level", 32'(level), 0);

    // Asynchronous reset mid-line, four pixels per word.
    step4(1'b1, w4(0), 1'b0, '0);
    step4(1'b1, w4(1), 1'b0, '0);
    step4(1'b0, '0, 1'b0, '0);
    step4(1'b0, '0, 1'b1, px4(0, 0));
    step4(1'b0, '0, 1'b1, px4(0, 1));
    chk("p4_pre_level", 32'(level4), 1);
    #2 rst4_n = 1'b0;
    #1;
    chk("arst_rgb", 32'({r4, g4, b4}), 0);
    chk("arst_de", 32'(de4), 0);
    chk("arst_level", 32'(level4), 0);
    chk("arst_flags", 32'({over4, under4}), 0);
    @(negedge clk);
    rst4_n = 1'b1;
    @(negedge clk);
    step4(1'b1, w4(2), 1'b0, '0);
    step4(1'b0, '0, 1'b0, '0);
    for (int l = 0; l < 4; l++) step4(1'b0, '0, 1'b1, px4(2, l));
    chk("p4_level", 32'(level4), 0);
    chk("p4_under", 32'(under4), 0);

    repeat (2) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    chk("exp4_q_empty", 32'(exp4_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
